// File: rtl/axi3_led_regs.sv
// AXI3 slave exposing four 32-bit registers: LED, SCRATCH, a constant ID and a free-running CYCLE counter.
// Read and write channels run as independent FSMs; the LED register drives o_led directly.
module axi3_led_regs #(
  parameter int unsigned ID_W     = 12,
  parameter logic [31:0] ID_VALUE = 32'h4C454438
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_AWVALID,
  input  logic [ID_W-1:0] i_AWID,
  input  logic [31:0]     i_AWADDR,
  input  logic [3:0]      i_AWLEN,
  input  logic [2:0]      i_AWSIZE,
  input  logic [1:0]      i_AWBURST,
  output logic            o_AWREADY,
  input  logic            i_WVALID,
  input  logic [ID_W-1:0] i_WID,
  input  logic [31:0]     i_WDATA,
  input  logic [3:0]      i_WSTRB,
  input  logic            i_WLAST,
  output logic            o_WREADY,
  output logic            o_BVALID,
  output logic [ID_W-1:0] o_BID,
  output logic [1:0]      o_BRESP,
  input  logic            i_BREADY,
  input  logic            i_ARVALID,
  input  logic [ID_W-1:0] i_ARID,
  input  logic [31:0]     i_ARADDR,
  input  logic [3:0]      i_ARLEN,
  input  logic [2:0]      i_ARSIZE,
  input  logic [1:0]      i_ARBURST,
  output logic            o_ARREADY,
  output logic            o_RVALID,
  output logic [ID_W-1:0] o_RID,
  output logic [31:0]     o_RDATA,
  output logic [1:0]      o_RRESP,
  output logic            o_RLAST,
  input  logic            i_RREADY,
  output logic [7:0]      o_led
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t        w_state;
  r_state_t        r_state;
  logic [7:0]      led_q;
  logic [31:0]     scratch_q;
  logic [31:0]     cycle_q;
  logic [ID_W-1:0] wid_q;
  logic [31:0]     waddr_q;
  logic [3:0]      wlen_q;
  logic [2:0]      wsize_q;
  logic [1:0]      wburst_q;
  logic [3:0]      wbeat_q;
  logic [1:0]      wacc_q;
  logic [31:0]     raddr_q;
  logic [3:0]      rlen_q;
  logic [2:0]      rsize_q;
  logic [1:0]      rburst_q;
  logic [3:0]      rbeat_q;
  logic [1:0]      w_resp_c;
  logic            w_en_c;
  logic [31:0]     r_addr_c;
  logic [2:0]      r_size_c;
  logic [1:0]      r_burst_c;
  logic [1:0]      r_resp_c;
  logic [31:0]     r_data_c;
  logic            unused_wid;

  // WID is deliberately not matched against the captured AWID.
  assign unused_wid = ^i_WID;
  assign o_led      = led_q;

  // Unsupported size/burst outranks decode; codes are ordered so max() gives the worst response.
  function automatic logic [1:0] beat_resp(input logic [9:0] idx, input logic [2:0] size,
                                           input logic [1:0] burst);
    logic [1:0] r;
    if (size != 3'b010 || (burst != BURST_FIXED && burst != BURST_INCR)) r = RESP_SLVERR;
    else if (idx > 10'd3)                                                   r = RESP_DECERR;
    else                                                                    r = RESP_OKAY;
    return r;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + 32'd4 : addr;
  endfunction

  always_comb begin
    w_resp_c = beat_resp(waddr_q[11:2], wsize_q, wburst_q);
    w_en_c   = o_WREADY && i_WVALID && (w_resp_c == RESP_OKAY);
  end

  // Address of the beat being loaded onto R: the AR address in idle, otherwise the next step.
  always_comb begin
    if (r_state == R_IDLE) begin
      r_addr_c  = i_ARADDR;
      r_size_c  = i_ARSIZE;
      r_burst_c = i_ARBURST;
    end else begin
      r_addr_c  = step_addr(raddr_q, rburst_q);
      r_size_c  = rsize_q;
      r_burst_c = rburst_q;
    end
    r_resp_c = beat_resp(r_addr_c[11:2], r_size_c, r_burst_c);
    r_data_c = '0;
    if (r_resp_c == RESP_OKAY) begin
      case (r_addr_c[11:2])
        10'd0:   r_data_c = {24'd0, led_q};
        10'd1:   r_data_c = scratch_q;
        10'd2:   r_data_c = ID_VALUE;
        10'd3:   r_data_c = cycle_q;
        default: r_data_c = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q     <= '0;
      scratch_q <= '0;
      cycle_q   <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (w_en_c) begin
        case (waddr_q[11:2])
          10'd0: if (i_WSTRB[0]) led_q <= i_WDATA[7:0];
          10'd1: for (int b = 0; b < 4; b++)
                   if (i_WSTRB[b]) scratch_q[8*b +: 8] <= i_WDATA[8*b +: 8];
          default: ;
        endcase
      end
    end
  end

  // Write channel FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state   <= W_IDLE;
      o_AWREADY <= 1'b1;
      o_WREADY  <= 1'b0;
      o_BVALID  <= 1'b0;
      o_BID     <= '0;
      o_BRESP   <= RESP_OKAY;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      wacc_q    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (i_AWVALID) begin
          wid_q     <= i_AWID;
          waddr_q   <= i_AWADDR;
          wlen_q    <= i_AWLEN;
          wsize_q   <= i_AWSIZE;
          wburst_q  <= i_AWBURST;
          wbeat_q   <= '0;
          wacc_q    <= RESP_OKAY;
          o_AWREADY <= 1'b0;
          o_WREADY  <= 1'b1;
          w_state   <= W_DATA;
        end
        W_DATA: if (i_WVALID) begin
          waddr_q <= step_addr(waddr_q, wburst_q);
          wbeat_q <= wbeat_q + 4'd1;
          wacc_q  <= worst(wacc_q, w_resp_c);
          if (i_WLAST) begin
            o_WREADY <= 1'b0;
            o_BVALID <= 1'b1;
            o_BID    <= wid_q;
            o_BRESP  <= worst(worst(wacc_q, w_resp_c),
                              (wbeat_q != wlen_q) ? RESP_SLVERR : RESP_OKAY);
            w_state  <= W_RESP;
          end
        end
        W_RESP: if (i_BREADY) begin
          o_BVALID  <= 1'b0;
          o_AWREADY <= 1'b1;
          w_state   <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: each beat is loaded on the AR handshake or the previous R handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= R_IDLE;
      o_ARREADY <= 1'b1;
      o_RVALID  <= 1'b0;
      o_RID     <= '0;
      o_RDATA   <= '0;
      o_RRESP   <= RESP_OKAY;
      o_RLAST   <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
    end else if (r_state == R_IDLE) begin
      if (i_ARVALID) begin
        raddr_q   <= r_addr_c;
        rlen_q    <= i_ARLEN;
        rsize_q   <= i_ARSIZE;
        rburst_q  <= i_ARBURST;
        rbeat_q   <= '0;
        o_ARREADY <= 1'b0;
        o_RVALID  <= 1'b1;
        o_RID     <= i_ARID;
        o_RDATA   <= r_data_c;
        o_RRESP   <= r_resp_c;
        o_RLAST   <= (i_ARLEN == 4'd0);
        r_state   <= R_DATA;
      end
    end else if (i_RREADY) begin
      if (o_RLAST) begin
        o_RVALID  <= 1'b0;
        o_RLAST   <= 1'b0;
        o_ARREADY <= 1'b1;
        r_state   <= R_IDLE;
      end else begin
        raddr_q <= r_addr_c;
        rbeat_q <= rbeat_q + 4'd1;
        o_RDATA <= r_data_c;
        o_RRESP <= r_resp_c;
        o_RLAST <= ((rbeat_q + 4'd1) == rlen_q);
      end
    end
  end

endmodule

// File: tb/tb_axi3_led_regs.sv
// Directed bench for axi3_led_regs: a single-beat write/read vector table plus hand-built burst,
// error, concurrency and mid-transaction reset sequences.
module tb_axi3_led_regs;

  localparam int unsigned ID_W = 12;
  localparam logic [31:0] ID_VAL = 32'h4C454438;
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic i_clk, i_rst;
  logic i_AWVALID; logic [ID_W-1:0] i_AWID; logic [31:0] i_AWADDR; logic [3:0] i_AWLEN;
  logic [2:0] i_AWSIZE; logic [1:0] i_AWBURST; logic o_AWREADY;
  logic i_WVALID; logic [ID_W-1:0] i_WID; logic [31:0] i_WDATA; logic [3:0] i_WSTRB;
  logic i_WLAST; logic o_WREADY;
  logic o_BVALID; logic [ID_W-1:0] o_BID; logic [1:0] o_BRESP; logic i_BREADY;
  logic i_ARVALID; logic [ID_W-1:0] i_ARID; logic [31:0] i_ARADDR; logic [3:0] i_ARLEN;
  logic [2:0] i_ARSIZE; logic [1:0] i_ARBURST; logic o_ARREADY;
  logic o_RVALID; logic [ID_W-1:0] o_RID; logic [31:0] o_RDATA; logic [1:0] o_RRESP;
  logic o_RLAST; logic i_RREADY;
  logic [7:0] o_led;

  axi3_led_regs dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_AWVALID(i_AWVALID), .i_AWID(i_AWID), .i_AWADDR(i_AWADDR), .i_AWLEN(i_AWLEN),
    .i_AWSIZE(i_AWSIZE), .i_AWBURST(i_AWBURST), .o_AWREADY(o_AWREADY),
    .i_WVALID(i_WVALID), .i_WID(i_WID), .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB),
    .i_WLAST(i_WLAST), .o_WREADY(o_WREADY),
    .o_BVALID(o_BVALID), .o_BID(o_BID), .o_BRESP(o_BRESP), .i_BREADY(i_BREADY),
    .i_ARVALID(i_ARVALID), .i_ARID(i_ARID), .i_ARADDR(i_ARADDR), .i_ARLEN(i_ARLEN),
    .i_ARSIZE(i_ARSIZE), .i_ARBURST(i_ARBURST), .o_ARREADY(o_ARREADY),
    .o_RVALID(o_RVALID), .o_RID(o_RID), .o_RDATA(o_RDATA), .o_RRESP(o_RRESP),
    .o_RLAST(o_RLAST), .i_RREADY(i_RREADY), .o_led(o_led)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference CYCLE counter: cleared by reset, +1 on every edge outside reset.
  logic [31:0] tb_cyc;
  always @(posedge i_clk or posedge i_rst)
    if (i_rst) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  logic [31:0]     rd   [16];
  logic [1:0]      rr   [16];
  logic            rl   [16];
  logic [31:0]     rcyc [16];
  logic [ID_W-1:0] rid0;

  task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    i_AWVALID = 1'b1; i_AWID = id; i_AWADDR = addr; i_AWLEN = len; i_AWSIZE = size; i_AWBURST = burst;
    while (!o_AWREADY && t < 50) begin @(negedge i_clk); t++; end
    if (!o_AWREADY) fail_now("aw_timeout");
    @(negedge i_clk);
    i_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t = 0;
    i_WVALID = 1'b1; i_WDATA = data; i_WSTRB = strb; i_WLAST = last; i_WID = '1;
    while (!o_WREADY && t < 50) begin @(negedge i_clk); t++; end
    if (!o_WREADY) fail_now("w_timeout");
    @(negedge i_clk);
    i_WVALID = 1'b0; i_WLAST = 1'b0;
  endtask

  task automatic b_get(output logic [1:0] resp, output logic [ID_W-1:0] id, output int lat);
    int t = 0;
    while (!o_BVALID && t < 50) begin @(negedge i_clk); t++; end
    lat = t; resp = o_BRESP; id = o_BID;
    if (!o_BVALID) fail_now("b_timeout");
    i_BREADY = 1'b1;
    @(negedge i_clk);
    i_BREADY = 1'b0;
  endtask

  task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    i_ARVALID = 1'b1; i_ARID = id; i_ARADDR = addr; i_ARLEN = len; i_ARSIZE = size; i_ARBURST = burst;
    while (!o_ARREADY && t < 50) begin @(negedge i_clk); t++; end
    if (!o_ARREADY) fail_now("ar_timeout");
    @(negedge i_clk);
    i_ARVALID = 1'b0;
  endtask

  // Collect len+1 beats; with toggle set, RREADY alternates so each later beat is stalled once.
  task automatic r_collect(input int len, input bit toggle);
    int beat = 0;
    int t = 0;
    bit fresh = 1'b1;
    bit hs;
    i_RREADY = 1'b0;
    while (beat <= len && t < 200) begin
      if (o_RVALID) begin
        if (fresh) begin
          rd[beat] = o_RDATA; rr[beat] = o_RRESP; rl[beat] = o_RLAST;
          rcyc[beat] = tb_cyc - 32'd1;
          if (beat == 0) rid0 = o_RID;
          fresh = 1'b0;
        end else begin
          check("r_stable_data", o_RDATA, rd[beat]);
          check("r_stable_last", 32'(o_RLAST), 32'(rl[beat]));
        end
        i_RREADY = toggle ? ~i_RREADY : 1'b1;
      end else begin
        i_RREADY = 1'b0;
      end
      hs = o_RVALID && i_RREADY;
      @(negedge i_clk);
      if (hs) begin beat++; fresh = 1'b1; end
      t++;
    end
    i_RREADY = 1'b0;
    if (beat <= len) fail_now("r_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_led"}, 32'(o_led), 32'h0);
    check({tag, "_ready"}, 32'({o_AWREADY, o_ARREADY, o_WREADY}), 32'b110);
    check({tag, "_valid"}, 32'({o_BVALID, o_RVALID}), 32'b00);
    check({tag, "_b"}, 32'({o_BID, o_BRESP}), 32'h0);
    check({tag, "_r"}, o_RDATA | 32'({o_RID, o_RRESP, o_RLAST}), 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [7:0]  led;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bresp;
    logic [ID_W-1:0] bid;
    int lat;

    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_00A5, 4'hF, OKAY,   32'h0000_00A5, OKAY,   8'hA5};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, OKAY,   32'hFFFF_FFFF, OKAY,   8'hA5};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'h5, OKAY,   32'hFF34_FF78, OKAY,   8'hA5};
    vecs[3] = '{1'b1, 32'h0000_0008, 32'h0000_0000, 4'hF, OKAY,   ID_VAL,        OKAY,   8'hA5};
    vecs[4] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, DECERR, 32'h0000_0000, DECERR, 8'hA5};
    vecs[5] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'h0, OKAY,   32'hFF34_FF78, OKAY,   8'hA5};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h1234_56C3, 4'h2, OKAY,   32'h0000_00A5, OKAY,   8'hA5};
    vecs[7] = '{1'b1, 32'hABCD_F006, 32'hCAFE_F00D, 4'hF, OKAY,   32'hCAFE_F00D, OKAY,   8'hA5};
    vecs[8] = '{1'b1, 32'h0000_0000, 32'h0000_FF3C, 4'h1, OKAY,   32'h0000_003C, OKAY,   8'h3C};
    vecs[9] = '{1'b1, 32'h0000_07FC, 32'h0000_0001, 4'hF, DECERR, 32'h0000_0000, DECERR, 8'h3C};

    i_rst = 1'b1;
    i_AWVALID = 0; i_AWID = '0; i_AWADDR = '0; i_AWLEN = '0; i_AWSIZE = '0; i_AWBURST = '0;
    i_WVALID = 0; i_WID = '0; i_WDATA = '0; i_WSTRB = '0; i_WLAST = 0; i_BREADY = 0;
    i_ARVALID = 0; i_ARID = '0; i_ARADDR = '0; i_ARLEN = '0; i_ARSIZE = '0; i_ARBURST = '0;
    i_RREADY = 0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst");
    i_rst = 1'b0;

    // First edge after reset loads CYCLE while it is still 0.
    ar_send(12'h001, 32'h0000_000C, 4'd0, 3'd2, INCR);
    r_collect(0, 1'b0);
    check("cycle_start", rd[0], 32'h0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        aw_send(ID_W'(12'h100 + i), vecs[i].addr, 4'd0, 3'd2, INCR);
        w_send(vecs[i].data, vecs[i].strb, 1'b1);
        check($sformatf("v%0d_led", i), 32'(o_led), 32'(vecs[i].led));
        b_get(bresp, bid, lat);
        check($sformatf("v%0d_bresp", i), 32'(bresp), 32'(vecs[i].bresp));
        check($sformatf("v%0d_bid", i), 32'(bid), 32'(12'h100 + i));
        check($sformatf("v%0d_blat", i), 32'(lat), 32'd0);
      end
      ar_send(ID_W'(12'h200 + i), vecs[i].addr, 4'd0, 3'd2, INCR);
      r_collect(0, 1'b0);
      check($sformatf("v%0d_rdata", i), rd[0], vecs[i].rdata);
      check($sformatf("v%0d_rresp", i), 32'(rr[0]), 32'(vecs[i].rresp));
      check($sformatf("v%0d_rlast", i), 32'(rl[0]), 32'd1);
      check($sformatf("v%0d_rid", i), 32'(rid0), 32'(12'h200 + i));
    end

    // Four-beat INCR read with RREADY stalls.
    ar_send(12'h0AB, 32'h0, 4'd3, 3'd2, INCR);
    r_collect(3, 1'b1);
    check("burst_d0", rd[0], 32'h0000_003C);
    check("burst_d1", rd[1], 32'hCAFE_F00D);
    check("burst_d2", rd[2], ID_VAL);
    check("burst_d3", rd[3], rcyc[3]);
    check("burst_last", 32'({rl[0], rl[1], rl[2], rl[3]}), 32'b0001);
    check("burst_resp", 32'({rr[0], rr[1], rr[2], rr[3]}), 32'h0);
    check("burst_idle", 32'({o_RVALID, o_ARREADY}), 32'b01);

    // Read errors.
    ar_send(12'h0B0, 32'h0, 4'd1, 3'd2, WRAP);
    r_collect(1, 1'b0);
    check("wrap_rd", rd[0] | rd[1], 32'h0);
    check("wrap_rr", 32'({rr[0], rr[1]}), 32'({SLVERR, SLVERR}));
    ar_send(12'h0B1, 32'h4, 4'd0, 3'd1, INCR);
    r_collect(0, 1'b0);
    check("size1_rr", 32'(rr[0]), 32'(SLVERR));
    check("size1_rd", rd[0], 32'h0);
    ar_send(12'h0B2, 32'h8, 4'd2, 3'd2, INCR);
    r_collect(2, 1'b0);
    check("cross_d", rd[0], ID_VAL);
    check("cross_cyc", rd[1], rcyc[1]);
    check("cross_rr", 32'({rr[0], rr[1], rr[2]}), 32'({OKAY, OKAY, DECERR}));
    check("cross_d2", rd[2], 32'h0);

    // WRAP write: SLVERR, SCRATCH untouched.
    aw_send(12'h0C0, 32'h4, 4'd0, 3'd2, WRAP);
    w_send(32'h0, 4'hF, 1'b1);
    b_get(bresp, bid, lat);
    check("wwrap_bresp", 32'(bresp), 32'(SLVERR));
    ar_send(12'h0C0, 32'h4, 4'd0, 3'd2, INCR);
    r_collect(0, 1'b0);
    check("wwrap_scratch", rd[0], 32'hCAFE_F00D);

    // Early WLAST: AWLEN=3, last on beat 1.
    aw_send(12'h0C1, 32'h0, 4'd3, 3'd2, INCR);
    w_send(32'h0000_0011, 4'hF, 1'b0);
    w_send(32'h2222_2222, 4'hF, 1'b1);
    b_get(bresp, bid, lat);
    check("early_bresp", 32'(bresp), 32'(SLVERR));
    check("early_led", 32'(o_led), 32'h11);

    // Late WLAST on FIXED: no response until WLAST, BVALID holds without BREADY.
    aw_send(12'h0C2, 32'h4, 4'd0, 3'd2, FIXED);
    w_send(32'h0000_0033, 4'hF, 1'b0);
    check("late_wait", 32'({o_BVALID, o_WREADY}), 32'b01);
    w_send(32'h0000_0044, 4'hF, 1'b1);
    repeat (2) @(negedge i_clk);
    check("late_hold", 32'({o_BVALID, o_BRESP, o_BID}), 32'({1'b1, SLVERR, 12'h0C2}));
    b_get(bresp, bid, lat);
    ar_send(12'h0C2, 32'h4, 4'd0, 3'd2, INCR);
    r_collect(0, 1'b0);
    check("late_scratch", rd[0], 32'h0000_0044);

    // 16-beat INCR write runs off the map (DECERR) and a 16-beat FIXED read of ID.
    aw_send(12'h0D0, 32'h0, 4'd15, 3'd2, INCR);
    for (int b = 0; b < 16; b++) w_send(32'hA0 + 32'(b), 4'hF, b == 15);
    b_get(bresp, bid, lat);
    check("len15_bresp", 32'(bresp), 32'(DECERR));
    check("len15_led", 32'(o_led), 32'hA0);
    ar_send(12'h0D1, 32'h8, 4'd15, 3'd2, FIXED);
    r_collect(15, 1'b0);
    check("len15_d", rd[0] ^ rd[15], 32'h0);
    check("len15_d15", rd[15], ID_VAL);
    check("len15_last", 32'({rl[14], rl[15]}), 32'b01);

    // Write handshake on the same edge a read beat of SCRATCH loads: read sees the old value.
    aw_send(12'h0E0, 32'h4, 4'd0, 3'd2, INCR);
    ar_send(12'h0E1, 32'h4, 4'd1, 3'd2, FIXED);
    check("race_d0", o_RDATA, 32'h0000_00A1);
    i_WVALID = 1'b1; i_WDATA = 32'h5555_AAAA; i_WSTRB = 4'hF; i_WLAST = 1'b1; i_RREADY = 1'b1;
    @(negedge i_clk);
    i_WVALID = 1'b0; i_WLAST = 1'b0; i_RREADY = 1'b0;
    check("race_d1", o_RDATA, 32'h0000_00A1);
    check("race_last", 32'({o_RVALID, o_RLAST}), 32'b11);
    i_RREADY = 1'b1;
    @(negedge i_clk);
    i_RREADY = 1'b0;
    b_get(bresp, bid, lat);
    ar_send(12'h0E2, 32'h4, 4'd0, 3'd2, INCR);
    r_collect(0, 1'b0);
    check("race_new", rd[0], 32'h5555_AAAA);

    // Reset with a read stalled in R_DATA and a write waiting in W_RESP.
    ar_send(12'h0F0, 32'h0, 4'd3, 3'd2, INCR);
    aw_send(12'h0F1, 32'h0, 4'd0, 3'd2, INCR);
    w_send(32'h0000_005A, 4'hF, 1'b1);
    check("prerst", 32'({o_RVALID, o_BVALID, o_led}), 32'({1'b1, 1'b1, 8'h5A}));
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset in the middle of a write data burst after SCRATCH was written.
    aw_send(12'h0F2, 32'h4, 4'd3, 3'd2, INCR);
    w_send(32'h1111_1111, 4'hF, 1'b0);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("wrst");
    @(negedge i_clk);
    i_rst = 1'b0;

    aw_send(12'h0F3, 32'h0, 4'd0, 3'd2, INCR);
    w_send(32'h0000_0081, 4'hF, 1'b1);
    b_get(bresp, bid, lat);
    check("post_b", 32'({bresp, bid}), 32'({OKAY, 12'h0F3}));
    check("post_led", 32'(o_led), 32'h81);
    ar_send(12'h0F4, 32'h4, 4'd0, 3'd2, INCR);
    r_collect(0, 1'b0);
    check("post_scratch", rd[0], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
